// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweeper.
// Latency: n/a (package only).
// Backpressure: n/a.
package sweep_pkg;

    localparam int N_IN  = 5;
    localparam int N_VEC = 32;
    localparam int CNT_W = 4;

    // Sweep FSM states: waiting for start, walking the vectors, completion pulse.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter timing how long each vector settles before sampling.
// Latency: zero flag is registered, valid the cycle after load.
// Backpressure: none; counts down every cycle and parks at zero.
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down and hold once zero is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Walks x through 0..31, waits SETTLE cycles per vector, captures y into table_q;
// optional golden-table comparator built when SWEEP_CHECK_EN is defined.
// Latency: 32*(SETTLE+1) cycles per sweep; no backpressure, start ignored while busy.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int unsigned       SETTLE   = 2,
    parameter logic [N_VEC-1:0]  EXPECTED = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic [N_IN-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic [N_VEC-1:0] table_q
`ifdef SWEEP_CHECK_EN
    ,
    output logic             mismatch,
    output logic [5:0]       err_count,
    output logic [N_IN-1:0]  first_err
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
    localparam logic [N_IN-1:0]  LAST_IDX  = N_IN'(N_VEC - 1);

    state_t state_q;
    logic   cnt_zero;
    logic   launch;
    logic   sample;
    logic   last_vec;
    logic   timer_load;

    // x doubles as the vector index; it is 0 whenever the FSM is idle.
    assign launch     = (state_q == ST_IDLE) && start;
    assign sample     = (state_q == ST_SETTLE) && cnt_zero;
    assign last_vec   = (x == LAST_IDX);
    assign timer_load = launch || (sample && !last_vec);

    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (SETTLE_LD),
        .zero     (cnt_zero)
    );

    // Sweep FSM with registered stimulus, status and captured table.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            table_q <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETTLE;
                        x       <= '0;
                        busy    <= 1'b1;
                        table_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_zero) begin
                        table_q[x] <= y;
                        if (last_vec) begin
                            state_q <= ST_DONE;
                            x       <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            x <= x + N_IN'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SWEEP_CHECK_EN
    logic bit_miss;

    assign bit_miss = (y != EXPECTED[x]);

    // Compare each captured bit with the golden table; first_err latches once.
    always_ff @(posedge clk) begin
        if (rst || launch) begin
            mismatch  <= 1'b0;
            err_count <= '0;
            first_err <= '0;
        end else if (sample && bit_miss) begin
            mismatch  <= 1'b1;
            err_count <= err_count + 6'd1;
            if (!mismatch) begin
                first_err <= x;
            end
        end
    end
`else
    // Without the comparator the golden table has no consumer.
    logic unused_expected;
    assign unused_expected = ^EXPECTED;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
`timescale 1ns/1ps
module tb_truth_table_sweeper;

    typedef struct {
        logic [31:0] tbl;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start2, start0;
    logic [1:0]  mode2, mode0;
    logic        y2, y0;
    logic [4:0]  x2, x0;
    logic        busy2, busy0, done2, done0;
    logic [31:0] tbl2, tbl0;
`ifdef SWEEP_CHECK_EN
    logic        mm2, mm0;
    logic [5:0]  ec2, ec0;
    logic [4:0]  fe2, fe0;
`endif

    // Function-block stubs selectable per test.
    function automatic logic yfun(input logic [1:0] m, input logic [4:0] v);
        case (m)
            2'd0:    return v[0];
            2'd1:    return v[4];
            2'd2:    return v[0] ^ (v == 5'd7);
            default: return v[1] ^ v[3];
        endcase
    endfunction

    assign y2 = yfun(mode2, x2);
    assign y0 = yfun(mode0, x0);

    truth_table_sweeper #(.SETTLE(2), .EXPECTED(32'hAAAA_AAAA)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2), .x(x2),
        .busy(busy2), .done(done2), .table_q(tbl2)
`ifdef SWEEP_CHECK_EN
        , .mismatch(mm2), .err_count(ec2), .first_err(fe2)
`endif
    );

    truth_table_sweeper #(.SETTLE(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0), .x(x0),
        .busy(busy0), .done(done0), .table_q(tbl0)
`ifdef SWEEP_CHECK_EN
        , .mismatch(mm0), .err_count(ec0), .first_err(fe0)
`endif
    );

    // sel=1 targets the SETTLE=2 instance, sel=0 the SETTLE=0 instance.
    logic        sel;
    logic        d_busy, d_done;
    logic [4:0]  d_x;
    logic [31:0] d_tbl;
    assign d_busy = sel ? busy2 : busy0;
    assign d_done = sel ? done2 : done0;
    assign d_x    = sel ? x2 : x0;
    assign d_tbl  = sel ? tbl2 : tbl0;

    int   n_checks = 0;
    int   n_err    = 0;
    exp_t sb[$];

    function automatic int settle_of(input logic s);
        return s ? 2 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else     start0 = v;
    endtask

    task automatic push_exp(input logic [31:0] tbl);
        exp_t e;
        e.tbl = tbl;
        e.lat = 32 * (settle_of(sel) + 1);
        sb.push_back(e);
    endtask

    // Drive start across one edge; the sweep must be visible right after it.
    task automatic kick(input bit push, input logic [31:0] tbl, input bit hold);
        if (push) push_exp(tbl);
        set_start(1'b1);
        @(negedge clk);
        if (!hold) set_start(1'b0);
        chk("start busy", {31'd0, d_busy}, 32'd1);
        chk("start x", {27'd0, d_x}, 32'd0);
    endtask

    // Follow one sweep to done, checking x stepping, latency and table.
    task automatic wait_done(input string tag, input int poke_at);
        exp_t e;
        int   n;
        int   s;
        bit   seen;
        bit   xok;
        s    = settle_of(sel);
        n    = 1;
        seen = 1'b0;
        xok  = 1'b1;
        while (!seen && n < 4000) begin
            @(negedge clk);
            n++;
            if (poke_at > 0) set_start(n == poke_at);
            if (d_done) seen = 1'b1;
            else if (d_busy && (d_x !== 5'((n - 1) / (s + 1)))) xok = 1'b0;
        end
        chk({tag, " done seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " x sequence"}, {31'd0, xok}, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " latency"}, n - 1, e.lat);
            chk({tag, " table"}, d_tbl, e.tbl);
        end else begin
            chk({tag, " scoreboard entry"}, 32'd0, 32'd1);
        end
        @(negedge clk);
        chk({tag, " done width"}, {31'd0, d_done}, 32'd0);
    endtask

    initial begin
        int          n;
        int          extra;
        logic [31:0] exp_tbl;

        rst    = 1'b1;
        start2 = 1'b0;
        start0 = 1'b0;
        mode2  = 2'd0;
        mode0  = 2'd1;
        sel    = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst x2", {27'd0, x2}, 32'd0);
        chk("rst busy2", {31'd0, busy2}, 32'd0);
        chk("rst done2", {31'd0, done2}, 32'd0);
        chk("rst tbl2", tbl2, 32'd0);
        chk("rst x0", {27'd0, x0}, 32'd0);
        chk("rst busy0", {31'd0, busy0}, 32'd0);
        chk("rst done0", {31'd0, done0}, 32'd0);
        chk("rst tbl0", tbl0, 32'd0);
`ifdef SWEEP_CHECK_EN
        chk("rst mismatch", {31'd0, mm2}, 32'd0);
        chk("rst err_count", {26'd0, ec2}, 32'd0);
        chk("rst first_err", {27'd0, fe2}, 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // One corrupted vector against the golden table.
        sel = 1'b1; mode2 = 2'd2;
        kick(1'b1, 32'hAAAA_AA2A, 1'b0);
        wait_done("xor7", 0);
`ifdef SWEEP_CHECK_EN
        chk("xor7 mismatch", {31'd0, mm2}, 32'd1);
        chk("xor7 err_count", {26'd0, ec2}, 32'd1);
        chk("xor7 first_err", {27'd0, fe2}, 32'd7);
`endif

        // Clean sweep, SETTLE=2; check outputs must clear at start.
        mode2 = 2'd0;
        kick(1'b1, 32'hAAAA_AAAA, 1'b0);
        wait_done("x0 settle2", 0);
`ifdef SWEEP_CHECK_EN
        chk("clean mismatch", {31'd0, mm2}, 32'd0);
        chk("clean err_count", {26'd0, ec2}, 32'd0);
`endif

        // SETTLE=0, one cycle per vector.
        sel = 1'b0; mode0 = 2'd1;
        kick(1'b1, 32'hFFFF_0000, 1'b0);
        wait_done("x4 settle0", 0);
`ifdef SWEEP_CHECK_EN
        chk("x4 err_count", {26'd0, ec0}, 32'd16);
        chk("x4 first_err", {27'd0, fe0}, 32'd16);
`endif

        // Reset in the middle of a sweep.
        sel = 1'b1; mode2 = 2'd0;
        kick(1'b0, 32'd0, 1'b0);
        n = 0;
        while (x2 !== 5'd12 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reach x12", {27'd0, x2}, 32'd12);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst x", {27'd0, x2}, 32'd0);
        chk("midrst busy", {31'd0, busy2}, 32'd0);
        chk("midrst tbl", tbl2, 32'd0);
        @(negedge clk);
        chk("midrst stays idle", {31'd0, busy2}, 32'd0);
        mode2 = 2'd3;
        exp_tbl = '0;
        for (int i = 0; i < 32; i++) exp_tbl[i] = yfun(2'd3, 5'(i));
        kick(1'b1, exp_tbl, 1'b0);
        wait_done("post reset", 0);

        // start pulsed mid-sweep is ignored; exactly one done.
        mode2 = 2'd0;
        kick(1'b1, 32'hAAAA_AAAA, 1'b0);
        wait_done("mid start", 20);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done2) extra++;
        end
        chk("mid start no extra done", extra, 0);

        // start held high: back-to-back sweeps with one idle cycle between.
        sel = 1'b0; mode0 = 2'd1;
        kick(1'b1, 32'hFFFF_0000, 1'b1);
        wait_done("held first", 0);
        chk("held idle gap", {31'd0, busy0}, 32'd0);
        mode0 = 2'd0;
        push_exp(32'hAAAA_AAAA);
        @(negedge clk);
        start0 = 1'b0;
        chk("held restart busy", {31'd0, busy0}, 32'd1);
        chk("held restart tbl cleared", tbl0, 32'd0);
        chk("held restart x", {27'd0, x0}, 32'd0);
        wait_done("held second", 0);
        @(negedge clk);
        chk("held release idle", {31'd0, busy0}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Sequencer for the 5-input gate-level function block and its mux8x1 tree. On `start` it drives every input vector 0..31 onto the block's `x[4:0]` and waits a programmable settle time. It then samples the 1-bit response `y` into a 32-bit truth-table register. It sits between the lab test harness and the function block, so the function can be characterised in hardware without a stimulus ROM.

## Interface
Parameters:
- `SETTLE`, default 2: idle cycles after each new vector before sampling. Range 0..15.
- `EXPECTED`, default 32'h0000_0000: golden truth table, bit *i* = expected `y` for `x == i`. Used only with `SWEEP_CHECK_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level; sampled in IDLE only.
- `y`  in  1  response of the function block; combinational from `x`.
- `x`  out  5  registered stimulus to the function block.
- `busy`  out  1  high in SETTLE state.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `table_q`  out  32  captured truth table.
- `mismatch`  out  1  sticky; any captured bit differs from `EXPECTED`. Exists only with `SWEEP_CHECK_EN`.
- `err_count`  out  6  number of differing bits, 0..32. Exists only with `SWEEP_CHECK_EN`.
- `first_err`  out  5  lowest index that mismatched. Exists only with `SWEEP_CHECK_EN`.

## Operation
- State machine states: IDLE, SETTLE, DONE.
- IDLE:
  - `x`=0, `busy`=0.
  - `start`=1 → SETTLE. Set index=0, `cnt`=`SETTLE`, clear `table_q`, clear check outputs.
- SETTLE:
  - `x`=index, `busy`=1.
  - `cnt`≠0: `cnt` decrements by 1.
  - `cnt`==0: `table_q[index]` ← `y`. Then:
    - index<31: index increments, `cnt` reloads to `SETTLE`.
    - index==31: → DONE.
- DONE:
  - `done`=1 for exactly one cycle, then → IDLE.
  - `table_q` holds until the next `start`.
- `start` while not in IDLE is ignored. There is no abort except `rst`.
- `start` held high re-triggers a new sweep on the cycle after DONE.
- Index is 5 bits. It never wraps within a sweep; the exit test is index==31.
- `cnt` width is 4 bits. `SETTLE`=0 is legal: each vector occupies exactly one cycle.
- Check logic, compiled in with `SWEEP_CHECK_EN`. On each sample where `y` ≠ `EXPECTED[index]`:
  - `mismatch` ← 1.
  - `err_count` ← `err_count` + 1. This saturation-free 6-bit count reaches at most 32.
  - On the first mismatch only, `first_err` ← index.

## Timing
- Reset values: `x`=0, `busy`=0, `done`=0, `table_q`=0, `mismatch`=0, `err_count`=0, `first_err`=0. State=IDLE, index=0, `cnt`=0.
- Reset mid-sweep: all of the above take effect on the next edge. The partial table is discarded.
- `start` sampled at edge *t*: `busy` and `x`=0 are visible after edge *t*.
- Each vector is held for `SETTLE`+1 cycles. `y` is sampled at the last edge of that window.
- Sweep length: 32·(`SETTLE`+1) cycles from entering SETTLE to entering DONE.
- `done` is high in the cycle after the last sample. `table_q` is final in that same cycle.
- Check outputs are final in the same cycle as `done`.

## Configuration
- Macro: `SWEEP_CHECK_EN`.
- Defined:
  - Comparator and the `mismatch`/`err_count`/`first_err` ports are built as described in Operation.
- Undefined:
  - Those ports and their logic are absent.
  - `EXPECTED` is unused.
  - Sweep behaviour and timing are identical to the defined case.

## Structure
- Shared package `sweep_pkg`:
  - state enum {IDLE, SETTLE, DONE}.
  - `N_IN`=5, `N_VEC`=32.
  - `CNT_W`=4.
- One sub-module, `sweep_settle_timer`:
  - Loadable down-counter.
  - Ports: `load`, `load_val`, `zero`.
  - Used by the FSM to time each vector.
- Comparator logic is inline, guarded by the macro.

## Test plan
- Stub `y`=`x[0]`, `SETTLE`=2, pulse `start` → `done` after 96 cycles, `table_q`=32'hAAAA_AAAA.
- Stub `y`=`x[4]`, `SETTLE`=0 → each `x` value held 1 cycle; `done` after 32 cycles; `table_q`=32'hFFFF_0000.
- `SWEEP_CHECK_EN`, `EXPECTED`=32'hAAAA_AAAA, stub `y`=`x[0]` XOR (`x`==7) → `mismatch`=1, `err_count`=1, `first_err`=7.
- Assert `rst` while `x`==12 → next cycle: `x`=0, `busy`=0, `table_q`=0. A new `start` then produces a full correct table.
- `start` pulsed mid-sweep → ignored; `done` asserts once, at the original 32·(`SETTLE`+1) point.
- `start` held high continuously → back-to-back sweeps. IDLE lasts 1 cycle between DONE and the next SETTLE. `table_q` clears at each restart.
